frame_ctrl: RTL and testbench
=============================

# frame_ctrl

Frame-synchronous controller for the VGA pixel datapath. Sits beside the `vga` timing generator on the same `clk` and consumes its `vsync`/`de`. It accepts configuration writes over a valid/ready port into shadow registers, then commits them atomically once per frame at the start of vertical sync. At each commit it advances the wrapped scroll offsets and frame counter that the pixel logic adds to `x`/`y`. This replaces clocking logic directly off `vsync`: everything runs on `clk`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible width; scroll_x modulus
- `V_ACTIVE`, 480, visible height; scroll_y modulus
- `VSYNC_ACTIVE_LOW`, 1, 1 = `vsync` asserted when low

Ports:
- `clk` in 1: pixel clock, same as `vga`
- `rst_n` in 1: asynchronous, active-low reset
- `vsync` in 1: from `vga`; polarity per `VSYNC_ACTIVE_LOW`
- `de` in 1: display enable from `vga`
- `cfg_valid` in 1: write request
- `cfg_addr` in 2: 0 = speed_x, 1 = speed_y, 2 = mode, 3 = ctrl
- `cfg_data` in 8: write data
- `cfg_ready` out 1: write accepted when `cfg_valid && cfg_ready`
- `cfg_pending` out 1: shadow differs from active (a write accepted since last commit)
- `mode` out 2: active `mode[1:0]` for the pixel logic
- `scroll_x` out 11: 0..H_ACTIVE-1
- `scroll_y` out 11: 0..V_ACTIVE-1
- `frame_cnt` out 16: commits since reset
- `frame_start` out 1: one-cycle pulse in the COMMIT cycle
- `line_start` out 1: one-cycle pulse after each `de` rise

## Operation
- Shadow registers: speed_x (s8), speed_y (s8), mode (2b, data[1:0]), ctrl (bit0 = scroll_en, bit1 = scroll_clr). Active copies mirror them.
- Writes go to the shadow only. Repeated writes to the same address before a commit: last one wins. An accepted write sets `cfg_pending`.
- Edge detect: `vs_act` = vsync XOR `VSYNC_ACTIVE_LOW`; `vs_q` is `vs_act` registered; edge = `vs_act && !vs_q`. `de_q` is handled the same way.
- FSM states:
  - INIT (reset state): cfg accepted; no scroll/frame update. On edge -> COMMIT.
  - COMMIT: exactly 1 cycle; `cfg_ready=0`; `frame_start=1`. Always -> RUN.
  - RUN: cfg accepted. On edge -> COMMIT.
- In COMMIT, all updates are registered at the end of the cycle:
  - active <- shadow; `cfg_pending` <- 0; `frame_cnt` += 1, wrapping at 16 bits.
  - Scroll uses the NEW shadow values. If scroll_clr: scroll_x = scroll_y = 0, and shadow ctrl bit1 self-clears. Else if scroll_en: scroll_x = wrap(scroll_x + sext(speed_x), H_ACTIVE), same for y with V_ACTIVE. Else hold.
  - wrap: compute in 12-bit signed; if <0 add modulus; if >= modulus subtract modulus. A single correction suffices because |speed| <= 128 < modulus.
  - Examples: 630+20 -> 10; 5-8 -> 637.
- `line_start` is independent of the FSM. It is active in INIT too.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Writes in flight are lost. FSM -> INIT.

## Timing
- Reset values: `cfg_ready`=1, `cfg_pending`=0, `mode`=0, `scroll_x`=0, `scroll_y`=0, `frame_cnt`=0, `frame_start`=0, `line_start`=0; all shadow/active regs 0; `vs_q`=0, `de_q`=0; FSM=INIT.
- Sequence: edge seen combinationally in cycle N; cycle N+1 is COMMIT (`frame_start`=1, `cfg_ready`=0); new `mode`/scroll/`frame_cnt` are visible from cycle N+2.
- A write accepted in cycle N is included in the commit at N+1.
- `cfg_valid` held during COMMIT stalls for one cycle and is accepted in N+2, counting toward the next frame.
- `cfg_pending` rises in the cycle after acceptance.
- `line_start`: `de` rise seen in cycle M -> pulse in M+1.
- `vsync` held active for many cycles gives exactly one commit. A `vsync` asserted at reset release produces no edge until it is deasserted and then reasserted.

## Test plan
- Reset then idle, no vsync: all outputs at reset values, `cfg_ready`=1, FSM stays in INIT, no `frame_start`.
- Write speed_x=20, ctrl=1, then 3 vsync edges from scroll_x=0: scroll_x = 20, 40, 60; `frame_cnt`=3; three single-cycle `frame_start` pulses; `cfg_pending` 1 -> 0 at first commit.
- Wrap cases: scroll_x=630 with speed_x=+20 -> 10; speed_x=0xF8 (-8) from 5 -> 637; scroll_y=470 with speed_y=+15 -> 5.
- `cfg_valid` held across the COMMIT cycle with mode=3: `cfg_ready` low exactly 1 cycle; `mode` stays old this frame and becomes 3 after the next edge.
- ctrl=3 at scroll_x=100: scroll_x/y -> 0 at commit. The next commit resumes advancing because bit1 self-cleared.
- Assert `rst_n` low mid-frame with pending writes: outputs return to reset values asynchronously; after release the stale writes are never committed.

Source files
------------

// File: rtl/frame_ctrl.sv
// Frame-synchronous configuration controller: shadows cfg writes, commits them
// once per frame at vsync onset and advances wrapped scroll offsets and frame count.
module frame_ctrl #(
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        de,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        cfg_ready,
  output logic        cfg_pending,
  output logic [1:0]  mode,
  output logic [10:0] scroll_x,
  output logic [10:0] scroll_y,
  output logic [15:0] frame_cnt,
  output logic        frame_start,
  output logic        line_start
);

  typedef enum logic [1:0] {ST_INIT, ST_COMMIT, ST_RUN} state_e;

  localparam logic [1:0] ADDR_SPEED_X = 2'd0;
  localparam logic [1:0] ADDR_SPEED_Y = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  state_e      state_q, state_d;
  logic        vs_act, vs_q, armed_q, vs_edge;
  logic        de_q, line_start_q, line_start_d;
  logic        accept, commit;
  logic [7:0]  sh_speed_x_q, sh_speed_x_d;
  logic [7:0]  sh_speed_y_q, sh_speed_y_d;
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [1:0]  sh_ctrl_q, sh_ctrl_d;
  logic [1:0]  mode_q, mode_d;
  logic        pending_q, pending_d;
  logic [10:0] scroll_x_q, scroll_x_d;
  logic [10:0] scroll_y_q, scroll_y_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // One conditional correction is enough since |speed| <= 128 < modulus.
  function automatic logic [10:0] wrap_add(input logic [10:0] pos,
                                           input logic [7:0]  spd,
                                           input int          modulus);
    logic signed [11:0] sum;
    logic signed [11:0] m;
    m   = 12'(modulus);
    sum = $signed({1'b0, pos}) + $signed({{4{spd[7]}}, spd});
    if (sum < 0)
      sum = sum + m;
    else if (sum >= m)
      sum = sum - m;
    return sum[10:0];
  endfunction

  // armed_q blocks a vsync already active at reset release from counting as an edge.
  assign vs_act  = vsync ^ VSYNC_ACTIVE_LOW;
  assign vs_edge = vs_act && !vs_q && armed_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_INIT, ST_RUN: if (vs_edge) state_d = ST_COMMIT;
      ST_COMMIT:       state_d = ST_RUN;
      default:         state_d = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready   = (state_q != ST_COMMIT);
    frame_start = (state_q == ST_COMMIT);
  end

  assign commit = (state_q == ST_COMMIT);
  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    sh_speed_x_d = sh_speed_x_q;
    sh_speed_y_d = sh_speed_y_q;
    sh_mode_d    = sh_mode_q;
    sh_ctrl_d    = sh_ctrl_q;
    mode_d       = mode_q;
    pending_d    = pending_q;
    scroll_x_d   = scroll_x_q;
    scroll_y_d   = scroll_y_q;
    frame_cnt_d  = frame_cnt_q;
    line_start_d = de && !de_q;

    if (accept) begin
      pending_d = 1'b1;
      unique case (cfg_addr)
        ADDR_SPEED_X: sh_speed_x_d = cfg_data;
        ADDR_SPEED_Y: sh_speed_y_d = cfg_data;
        ADDR_MODE:    sh_mode_d    = cfg_data[1:0];
        ADDR_CTRL:    sh_ctrl_d    = cfg_data[1:0];
        default:      ;
      endcase
    end

    // accept and commit never coincide: cfg_ready is low during COMMIT.
    if (commit) begin
      mode_d      = sh_mode_q;
      pending_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (sh_ctrl_q[1]) begin
        scroll_x_d   = '0;
        scroll_y_d   = '0;
        sh_ctrl_d[1] = 1'b0;
      end else if (sh_ctrl_q[0]) begin
        scroll_x_d = wrap_add(scroll_x_q, sh_speed_x_q, H_ACTIVE);
        scroll_y_d = wrap_add(scroll_y_q, sh_speed_y_q, V_ACTIVE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b0;
      armed_q      <= 1'b0;
      de_q         <= 1'b0;
      line_start_q <= 1'b0;
      sh_speed_x_q <= '0;
      sh_speed_y_q <= '0;
      sh_mode_q    <= '0;
      sh_ctrl_q    <= '0;
      mode_q       <= '0;
      pending_q    <= 1'b0;
      scroll_x_q   <= '0;
      scroll_y_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vs_q         <= vs_act;
      armed_q      <= armed_q || !vs_act;
      de_q         <= de;
      line_start_q <= line_start_d;
      sh_speed_x_q <= sh_speed_x_d;
      sh_speed_y_q <= sh_speed_y_d;
      sh_mode_q    <= sh_mode_d;
      sh_ctrl_q    <= sh_ctrl_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      scroll_x_q   <= scroll_x_d;
      scroll_y_q   <= scroll_y_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign cfg_pending = pending_q;
  assign mode        = mode_q;
  assign scroll_x    = scroll_x_q;
  assign scroll_y    = scroll_y_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Self-checking bench for frame_ctrl: directed frame scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_frame_ctrl;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b1;
  logic        de = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_ready, cfg_pending, frame_start, line_start;
  logic [1:0]  mode;
  logic [10:0] scroll_x, scroll_y;
  logic [15:0] frame_cnt;

  frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .de(de),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_pending(cfg_pending), .mode(mode),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .frame_cnt(frame_cnt),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fs_seen = 0;
  int rdy_low_seen = 0;

  // Reference model state (frame-level view)
  int m_sx, m_sy, m_fc, m_mode, m_pend;
  int sh_spx, sh_spy, sh_mode;
  bit sh_en, sh_clr;
  bit m_commit, m_ls, m_vs_prev, m_de_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sext8(input logic [7:0] d);
    return d[7] ? int'(d) - 256 : int'(d);
  endfunction

  function automatic int wrapm(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  task automatic set_vs(input bit active);
    vsync = ~active;
  endtask

  // After reset a vsync counts as "already active" until seen inactive once.
  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_fc = 0; m_mode = 0; m_pend = 0;
    sh_spx = 0; sh_spy = 0; sh_mode = 0; sh_en = 0; sh_clr = 0;
    m_commit = 0; m_ls = 0; m_vs_prev = 1; m_de_prev = 0;
  endtask

  task automatic model_clock();
    bit vs_a, edge_now, acc;
    vs_a     = ~vsync;
    edge_now = vs_a && !m_vs_prev && !m_commit;
    acc      = cfg_valid && !m_commit;
    if (m_commit) begin
      m_mode = sh_mode;
      m_pend = 0;
      m_fc   = (m_fc + 1) % 65536;
      if (sh_clr) begin
        m_sx = 0; m_sy = 0; sh_clr = 0;
      end else if (sh_en) begin
        m_sx = wrapm(m_sx + sh_spx, H);
        m_sy = wrapm(m_sy + sh_spy, V);
      end
    end
    if (acc) begin
      m_pend = 1;
      case (cfg_addr)
        2'd0: sh_spx = sext8(cfg_data);
        2'd1: sh_spy = sext8(cfg_data);
        2'd2: sh_mode = int'(cfg_data[1:0]);
        default: begin sh_en = cfg_data[0]; sh_clr = cfg_data[1]; end
      endcase
    end
    m_ls      = de && !m_de_prev;
    m_de_prev = de;
    m_vs_prev = vs_a;
    m_commit  = edge_now;
  endtask

  task automatic check_outputs();
    check("cfg_ready",   32'(cfg_ready),   32'(!m_commit));
    check("frame_start", 32'(frame_start), 32'(m_commit));
    check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    check("mode",        32'(mode),        32'(m_mode));
    check("scroll_x",    32'(scroll_x),    32'(m_sx));
    check("scroll_y",    32'(scroll_y),    32'(m_sy));
    check("frame_cnt",   32'(frame_cnt),   32'(m_fc));
    check("line_start",  32'(line_start),  32'(m_ls));
  endtask

  task automatic step();
    de = 1'($urandom_range(0, 1));
    model_clock();
    @(posedge clk);
    #1;
    if (frame_start) fs_seen++;
    if (!cfg_ready) rdy_low_seen++;
    check_outputs();
  endtask

  task automatic write_cfg(input logic [1:0] addr, input logic [7:0] data);
    bit acc, done;
    done = 0;
    cfg_valid = 1'b1; cfg_addr = addr; cfg_data = data;
    for (int i = 0; i < 4; i++) begin
      acc = !m_commit;
      step();
      if (acc) begin done = 1; break; end
    end
    cfg_valid = 1'b0;
    if (!done) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic vs_pulse(input int hi, input int lo);
    set_vs(1'b1);
    repeat (hi) step();
    set_vs(1'b0);
    repeat (lo) step();
  endtask

  // Reset is asserted and released between clock edges; outputs checked while held.
  task automatic do_reset();
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    check("rst_pending", 32'(cfg_pending), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  int vs_cnt;
  bit vs_state;
  int rl0;

  initial begin
    // Reset then idle with vsync inactive: nothing commits
    set_vs(1'b0);
    do_reset();
    repeat (20) step();
    check("idle_fc", 32'(frame_cnt), 32'd0);
    check("idle_fs", 32'(fs_seen), 32'd0);

    // Three frames at speed 20
    write_cfg(2'd0, 8'd20);
    write_cfg(2'd3, 8'd1);
    check("pend_before", 32'(cfg_pending), 32'd1);
    vs_pulse(5, 20);
    check("sx_f1", 32'(scroll_x), 32'd20);
    check("pend_after", 32'(cfg_pending), 32'd0);
    vs_pulse(5, 20);
    check("sx_f2", 32'(scroll_x), 32'd40);
    vs_pulse(30, 20);
    check("sx_f3", 32'(scroll_x), 32'd60);
    check("fc_f3", 32'(frame_cnt), 32'd3);
    check("fs_pulses", 32'(fs_seen), 32'd3);

    // Wrap cases
    do_reset();
    write_cfg(2'd0, 8'd90);
    write_cfg(2'd3, 8'd1);
    repeat (7) vs_pulse(3, 8);
    check("sx_630", 32'(scroll_x), 32'd630);
    write_cfg(2'd0, 8'd20);
    vs_pulse(3, 8);
    check("sx_wrap_hi", 32'(scroll_x), 32'd10);
    write_cfg(2'd0, 8'hFB);
    vs_pulse(3, 8);
    check("sx_5", 32'(scroll_x), 32'd5);
    write_cfg(2'd0, 8'hF8);
    vs_pulse(3, 8);
    check("sx_wrap_lo", 32'(scroll_x), 32'd637);
    write_cfg(2'd0, 8'd0);
    write_cfg(2'd1, 8'd94);
    repeat (5) vs_pulse(3, 8);
    check("sy_470", 32'(scroll_y), 32'd470);
    write_cfg(2'd1, 8'd15);
    vs_pulse(3, 8);
    check("sy_wrap", 32'(scroll_y), 32'd5);
    check("sx_hold", 32'(scroll_x), 32'd637);

    // cfg_valid held across COMMIT
    do_reset();
    repeat (3) step();
    rl0 = rdy_low_seen;
    set_vs(1'b1);
    step();
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd3;
    step();
    step();
    cfg_valid = 1'b0;
    repeat (4) step();
    set_vs(1'b0);
    repeat (4) step();
    check("rdy_low_1cyc", 32'(rdy_low_seen - rl0), 32'd1);
    check("mode_old", 32'(mode), 32'd0);
    check("mode_pend", 32'(cfg_pending), 32'd1);
    vs_pulse(3, 5);
    check("mode_new", 32'(mode), 32'd3);

    // Scroll clear then resume
    do_reset();
    write_cfg(2'd0, 8'd100);
    write_cfg(2'd3, 8'd1);
    vs_pulse(3, 6);
    check("sx_100", 32'(scroll_x), 32'd100);
    write_cfg(2'd3, 8'd3);
    vs_pulse(3, 6);
    check("clr_sx", 32'(scroll_x), 32'd0);
    check("clr_sy", 32'(scroll_y), 32'd0);
    vs_pulse(3, 6);
    check("resume_sx", 32'(scroll_x), 32'd100);

    // Reset mid-frame discards pending shadow writes
    write_cfg(2'd0, 8'd50);
    write_cfg(2'd2, 8'd2);
    check("pend_pre_rst", 32'(cfg_pending), 32'd1);
    do_reset();
    repeat (3) step();
    vs_pulse(3, 6);
    check("stale_sx", 32'(scroll_x), 32'd0);
    check("stale_mode", 32'(mode), 32'd0);
    check("stale_fc", 32'(frame_cnt), 32'd1);

    // vsync active across reset release gives no commit until re-asserted
    set_vs(1'b1);
    do_reset();
    rl0 = fs_seen;
    repeat (10) step();
    check("vs_at_rst_fc", 32'(frame_cnt), 32'd0);
    check("vs_at_rst_fs", 32'(fs_seen - rl0), 32'd0);
    set_vs(1'b0);
    repeat (3) step();
    vs_pulse(3, 3);
    check("vs_rearm_fc", 32'(frame_cnt), 32'd1);

    // Random traffic
    vs_state = 1'b0;
    vs_cnt = 10;
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_addr  = 2'($urandom);
      cfg_data  = 8'($urandom);
      if (vs_cnt == 0) begin
        vs_state = ~vs_state;
        vs_cnt = $urandom_range(1, 40);
      end else begin
        vs_cnt--;
      end
      set_vs(vs_state);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    cfg_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
